// File: rtl/gouram_datatypes.sv
`default_nettype none
// ============================================================================
// gouram_datatypes : shared timestamp type and NOT_FOUND sentinel
// Rev 1.0
// ============================================================================
package gouram_datatypes;

  localparam int DEFAULT_TIME_WIDTH = 32;

  typedef logic signed [DEFAULT_TIME_WIDTH-1:0] time_t;

  localparam time_t NOT_FOUND = -1;

endpackage
`default_nettype wire

// File: rtl/signal_history_sreg.sv
`default_nettype none
// ============================================================================
// signal_history_sreg : DEPTH-bit history shift register, age 0 = newest
// Rev 1.0
// ============================================================================
module signal_history_sreg #(
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [DEPTH-1:0] hist
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= '0;
    end else begin
      hist <= {hist[DEPTH-2:0], din};
    end
  end

endmodule
`default_nettype wire

// File: rtl/signal_history_tracker.sv
`default_nettype none
// ============================================================================
// signal_history_tracker : per-cycle history of one signal with time-test
// (pulse edges in a look-back window) and value-find queries.  Rev 1.0
// ============================================================================
module signal_history_tracker
  import gouram_datatypes::*;
#(
  parameter int DEPTH      = 128,
  parameter int TIME_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [TIME_WIDTH-1:0] counter,
  input  logic                         signal_in,
  input  logic signed [TIME_WIDTH-1:0] tt_window,
  input  logic                         tt_req,
  output logic                         tt_valid,
  output logic signed [TIME_WIDTH-1:0] tt_start,
  output logic signed [TIME_WIDTH-1:0] tt_end,
  input  logic signed [TIME_WIDTH-1:0] vf_cycles_back,
  input  logic                         vf_req,
  output logic                         vf_valid,
  output logic                         vf_recall
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int LIMW = IDXW + 1;
  localparam logic signed [TIME_WIDTH-1:0] NF = TIME_WIDTH'(NOT_FOUND);

  logic [DEPTH-1:0] hist;

  signal_history_sreg #(.DEPTH(DEPTH)) u_sreg (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (signal_in),
    .hist  (hist)
  );

  // Number of ages searched; capped at DEPTH-1 so hist[k+1] always exists.
  logic [LIMW-1:0] win_lim;

  always_comb begin
    if (tt_window <= 0) begin
      win_lim = '0;
    end else if (tt_window >= TIME_WIDTH'(DEPTH - 1)) begin
      win_lim = LIMW'(DEPTH - 1);
    end else begin
      win_lim = LIMW'(tt_window);
    end
  end

  logic            start_found;
  logic            end_found;
  logic [LIMW-1:0] start_age;
  logic [LIMW-1:0] end_age;

  // Ascending scans: the last hit is the oldest edge in range.
  always_comb begin
    start_found = 1'b0;
    start_age   = '0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if ((LIMW'(k) < win_lim) && hist[k] && !hist[k+1]) begin
        start_found = 1'b1;
        start_age   = LIMW'(k);
      end
    end
    end_found = 1'b0;
    end_age   = '0;
    for (int j = 1; j < DEPTH; j++) begin
      if ((LIMW'(j) < win_lim) && (!start_found || (LIMW'(j) <= start_age)) &&
          hist[j] && !hist[j-1]) begin
        end_found = 1'b1;
        end_age   = LIMW'(j);
      end
    end
  end

  logic signed [TIME_WIDTH-1:0] start_ts;
  logic signed [TIME_WIDTH-1:0] end_ts;

  assign start_ts = counter - TIME_WIDTH'(1) - TIME_WIDTH'(start_age);
  assign end_ts   = counter - TIME_WIDTH'(1) - TIME_WIDTH'(end_age);

  logic recall_now;

  always_comb begin
    if (vf_cycles_back <= 0) begin
      recall_now = signal_in;
    end else if (vf_cycles_back > TIME_WIDTH'(DEPTH)) begin
      recall_now = 1'b0;
    end else begin
      recall_now = hist[IDXW'(vf_cycles_back - TIME_WIDTH'(1))];
    end
  end

  // Level handshake: accept only while idle, hold result until req drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tt_valid <= 1'b0;
      tt_start <= NF;
      tt_end   <= NF;
    end else if (tt_req && !tt_valid) begin
      tt_valid <= 1'b1;
      tt_start <= start_found ? start_ts : NF;
      tt_end   <= end_found ? end_ts : NF;
    end else if (!tt_req) begin
      tt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vf_valid  <= 1'b0;
      vf_recall <= 1'b0;
    end else if (vf_req && !vf_valid) begin
      vf_valid  <= 1'b1;
      vf_recall <= recall_now;
    end else if (!vf_req) begin
      vf_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_signal_history_tracker.sv
`default_nettype none
// ============================================================================
// tb_signal_history_tracker : directed vector table plus handshake/reset
// sequences for signal_history_tracker.  Rev 1.0
// ============================================================================
module tb_signal_history_tracker;
  import gouram_datatypes::*;

  localparam int DEPTH = 128;
  localparam int TW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic signed [TW-1:0] counter = '0;
  logic          signal_in = 1'b0;
  logic signed [TW-1:0] tt_window = '0;
  logic          tt_req = 1'b0;
  logic          tt_valid;
  logic signed [TW-1:0] tt_start;
  logic signed [TW-1:0] tt_end;
  logic signed [TW-1:0] vf_cycles_back = '0;
  logic          vf_req = 1'b0;
  logic          vf_valid;
  logic          vf_recall;

  signal_history_tracker #(.DEPTH(DEPTH), .TIME_WIDTH(TW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .counter        (counter),
    .signal_in      (signal_in),
    .tt_window      (tt_window),
    .tt_req         (tt_req),
    .tt_valid       (tt_valid),
    .tt_start       (tt_start),
    .tt_end         (tt_end),
    .vf_cycles_back (vf_cycles_back),
    .vf_req         (vf_req),
    .vf_valid       (vf_valid),
    .vf_recall      (vf_recall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pattern = 0;

  typedef struct {
    int pat;
    int req_c;
    int win;
    int nback;
    int exp_start;
    int exp_end;
    int exp_recall;
  } vec_t;

  vec_t vecs[11];

  // 0: high 10..14; 1: high from 30; 2: high 10..14 and 20; 3: always high
  function automatic logic pat_val(input int p, input int c);
    case (p)
      0:       return (c >= 10 && c <= 14);
      1:       return (c >= 30);
      2:       return (c >= 10 && c <= 14) || (c == 20);
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    counter   = counter + 1;
    signal_in = pat_val(pattern, int'(counter));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    tt_req    = 1'b0;
    vf_req    = 1'b0;
    counter   = '0;
    signal_in = pat_val(pattern, 0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_to(input int c);
    for (int n = 0; n < 200 && int'(counter) < c; n++) step();
  endtask

  initial begin
    vecs[0]  = '{0, 20,   15,   8,  10,  14, 1};
    vecs[1]  = '{0, 20,    8,   3,  -1,  14, 0};
    vecs[2]  = '{0, 20,   15, 200,  10,  14, 0};
    vecs[3]  = '{2, 20,   15,   0,  10,  14, 1};
    vecs[4]  = '{1, 35,   10,   5,  30,  -1, 1};
    vecs[5]  = '{1, 35,    0,   6,  -1,  -1, 0};
    vecs[6]  = '{0, 20,   -3,  -2,  -1,  -1, 0};
    vecs[7]  = '{0, 20, 1000, 128,  10,  14, 0};
    vecs[8]  = '{1, 35,    5,   1,  30,  -1, 1};
    vecs[9]  = '{1, 35,    4,   6,  -1,  -1, 0};
    vecs[10] = '{3,  4,   10,   3,   1,  -1, 1};

    pattern = 0;
    do_reset();
    chk("reset tt_valid", int'(tt_valid), 0);
    chk("reset tt_start", int'(tt_start), -1);
    chk("reset tt_end", int'(tt_end), -1);
    chk("reset vf_valid", int'(vf_valid), 0);
    chk("reset vf_recall", int'(vf_recall), 0);

    for (int i = 0; i < 11; i++) begin
      pattern = vecs[i].pat;
      do_reset();
      run_to(vecs[i].req_c);
      tt_window      = vecs[i].win;
      vf_cycles_back = vecs[i].nback;
      tt_req         = 1'b1;
      vf_req         = 1'b1;
      step();
      chk($sformatf("v%0d tt_valid", i), int'(tt_valid), 1);
      chk($sformatf("v%0d tt_start", i), int'(tt_start), vecs[i].exp_start);
      chk($sformatf("v%0d tt_end", i), int'(tt_end), vecs[i].exp_end);
      chk($sformatf("v%0d vf_valid", i), int'(vf_valid), 1);
      chk($sformatf("v%0d vf_recall", i), int'(vf_recall), vecs[i].exp_recall);
      tt_req = 1'b0;
      vf_req = 1'b0;
      step();
      chk($sformatf("v%0d tt_valid drop", i), int'(tt_valid), 0);
      chk($sformatf("v%0d vf_valid drop", i), int'(vf_valid), 0);
    end

    // Handshake: hold, release for one edge, re-request with a newer counter.
    pattern = 0;
    do_reset();
    run_to(20);
    tt_window = 15;
    tt_req    = 1'b1;
    chk("hs idle before accept", int'(tt_valid), 0);
    step();
    chk("hs accept valid", int'(tt_valid), 1);
    chk("hs accept start", int'(tt_start), 10);
    for (int h = 0; h < 3; h++) begin
      step();
      chk($sformatf("hs hold%0d valid", h), int'(tt_valid), 1);
      chk($sformatf("hs hold%0d start", h), int'(tt_start), 10);
      chk($sformatf("hs hold%0d end", h), int'(tt_end), 14);
    end
    chk("hs counter", int'(counter), 24);
    tt_req = 1'b0;
    step();
    chk("hs drop valid", int'(tt_valid), 0);
    tt_window = 12;
    tt_req    = 1'b1;
    step();
    chk("hs renew valid", int'(tt_valid), 1);
    chk("hs renew start", int'(tt_start), -1);
    chk("hs renew end", int'(tt_end), 14);
    tt_req = 1'b0;
    step();

    // Reset while both results are valid and requests still high.
    pattern = 3;
    do_reset();
    run_to(6);
    tt_window      = 10;
    vf_cycles_back = 2;
    tt_req         = 1'b1;
    vf_req         = 1'b1;
    step();
    chk("rs pre valid", int'(tt_valid), 1);
    chk("rs pre start", int'(tt_start), 1);
    chk("rs pre recall", int'(vf_recall), 1);
    rst_n = 1'b0;
    step();
    chk("rs tt_valid", int'(tt_valid), 0);
    chk("rs tt_start", int'(tt_start), -1);
    chk("rs tt_end", int'(tt_end), -1);
    chk("rs vf_valid", int'(vf_valid), 0);
    chk("rs vf_recall", int'(vf_recall), 0);
    rst_n  = 1'b1;
    tt_req = 1'b0;
    vf_req = 1'b0;
    run_to(11);
    vf_cycles_back = 4;
    tt_req         = 1'b1;
    vf_req         = 1'b1;
    step();
    chk("rs post valid", int'(tt_valid), 1);
    chk("rs post start", int'(tt_start), 8);
    chk("rs post end", int'(tt_end), -1);
    chk("rs post recall age3", int'(vf_recall), 0);
    tt_req = 1'b0;
    vf_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
